// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial adder-subtractor.
package addsub_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation select values for the sub input
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of a counter that indexes n chunks; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fa_chunk.sv
// Combinational ripple of CHUNK full adders. Besides the carry out it exposes
// the carry into the top bit so the caller can derive signed overflow.
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c_s;

  // Bit-by-bit ripple from the carry-in to the carry-out
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = x[i] ^ y[i] ^ c_s[i];
      c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
    end
  end

  assign co       = c_s[CHUNK];
  assign c_msb_in = c_s[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle adder-subtractor: one CHUNK-wide ripple slice is reused for
// WIDTH/CHUNK cycles. Subtraction is a + ~b + !cin, so cout=1 means no borrow.
// Optional build macro SAT_EN: clamp the result to signed max/min on overflow.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state_r, state_s;
  logic             load_s, step_s, last_s;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] op_a_r, op_b_r, sum_r;
  logic             carry_r;
  int               idx_off_s;
  logic [CHUNK-1:0] x_s, y_s, s_s;
  logic             co_s, c_msb_s, ovf_s;
  logic [WIDTH-1:0] sum_full_s, final_s;

  // Select the active chunk of each operand and merge its sum into the word
  always_comb begin
    idx_off_s  = int'(idx_r) * CHUNK;
    x_s        = op_a_r[idx_off_s +: CHUNK];
    y_s        = op_b_r[idx_off_s +: CHUNK];
    sum_full_s = sum_r;
    sum_full_s[idx_off_s +: CHUNK] = s_s;
  end

  fa_chunk #(.CHUNK(CHUNK)) u_slice (
    .x        (x_s),
    .y        (y_s),
    .ci       (carry_r),
    .s        (s_s),
    .co       (co_s),
    .c_msb_in (c_msb_s)
  );

  assign last_s = (idx_r == IW'(NCHUNK - 1));
  // Only meaningful on the last chunk, whose top bit is the word MSB
  assign ovf_s  = co_s ^ c_msb_s;

`ifdef SAT_EN
  // Clamp toward the sign of operand A when the signed result overflowed
  always_comb begin
    if (ovf_s) begin
      final_s = op_a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_s = sum_full_s;
    end
  end
`else
  assign final_s = sum_full_s;
`endif

  // Next-state and datapath strobes
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s = ST_RUN;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register with registered busy/done decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == ST_RUN);
      done    <= (state_s == ST_DONE);
    end
  end

  // Operand capture, chunk-by-chunk accumulation and final output load
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r  <= '0;
      op_b_r  <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load_s) begin
      op_a_r  <= a;
      op_b_r  <= b ^ {WIDTH{sub}};
      carry_r <= cin ^ sub;
      sum_r   <= '0;
      idx_r   <= '0;
    end else if (step_s) begin
      sum_r   <= sum_full_s;
      carry_r <= co_s;
      idx_r   <= idx_r + IW'(1);
      if (last_s) begin
        result <= final_s;
        cout   <= co_s;
        ovf    <= ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and random self-checking bench for addsub_serial (WIDTH=16, CHUNK=4).
// Honours SAT_EN the same way as the design when computing expectations.
module tb_addsub_serial;
  import addsub_pkg::*;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  addsub_serial #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, result} from sign-based overflow rule
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms, input logic mc);
    logic [W-1:0] bb;
    logic         ci, v;
    logic [W:0]   f;
    logic [W-1:0] r;
    bb = ms ? ~mb : mb;
    ci = ms ? ~mc : mc;
    f  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
    v  = (ma[W-1] == bb[W-1]) && (f[W-1] != ma[W-1]);
    r  = f[W-1:0];
`ifdef SAT_EN
    if (v) r = ma[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {v, f[W], r};
  endfunction

  // Issue one op, scramble inputs during RUN, wait (bounded) for done
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input logic tc, output int lat, output int busy_cnt);
    @(negedge clk);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb; sub = ~ts; cin = ~tc;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 64) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, cout, ovf, result} !== {4'b0000, 16'h0000}) begin
      failures++;
      $display("FAIL reset_state got=%b_%h exp=0000_0000", {busy, done, cout, ovf}, result);
    end
  endtask

  task automatic test_add();
    int lat, bc;
    run_op(16'h1234, 16'h1111, MODE_ADD, 1'b0, lat, bc);
    checks++;
    if (lat !== NC) begin failures++; $display("FAIL add_latency got=%0d exp=%0d", lat, NC); end
    checks++;
    if (bc !== NC) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=%0d", bc, NC); end
    checks++;
    if ({ovf, cout, result} !== {2'b00, 16'h2345}) begin
      failures++; $display("FAIL add_basic got=%b%b_%h exp=00_2345", ovf, cout, result);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
  endtask

  task automatic test_sub();
    int lat, bc;
    run_op(16'h0005, 16'h0007, MODE_SUB, 1'b0, lat, bc);
    checks++;
    if ({ovf, cout, result} !== {2'b00, 16'hFFFE}) begin
      failures++; $display("FAIL sub_borrow got=%b%b_%h exp=00_fffe", ovf, cout, result);
    end
    run_op(16'h0007, 16'h0005, MODE_SUB, 1'b0, lat, bc);
    checks++;
    if ({ovf, cout, result} !== {2'b01, 16'h0002}) begin
      failures++; $display("FAIL sub_noborrow got=%b%b_%h exp=01_0002", ovf, cout, result);
    end
    run_op(16'h0007, 16'h0005, MODE_SUB, 1'b1, lat, bc);
    checks++;
    if ({ovf, cout, result} !== {2'b01, 16'h0001}) begin
      failures++; $display("FAIL sub_borrow_in got=%b%b_%h exp=01_0001", ovf, cout, result);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    logic [W-1:0] exp1, exp2;
`ifdef SAT_EN
    exp1 = 16'h7FFF; exp2 = 16'h8000;
`else
    exp1 = 16'h8000; exp2 = 16'h7FFF;
`endif
    run_op(16'h7FFF, 16'h0001, MODE_ADD, 1'b0, lat, bc);
    checks++;
    if ({ovf, cout, result} !== {2'b10, exp1}) begin
      failures++; $display("FAIL ovf_add got=%b%b_%h exp=10_%h", ovf, cout, result, exp1);
    end
    run_op(16'h8000, 16'h0001, MODE_SUB, 1'b0, lat, bc);
    checks++;
    if ({ovf, cout, result} !== {2'b11, exp2}) begin
      failures++; $display("FAIL ovf_sub got=%b%b_%h exp=11_%h", ovf, cout, result, exp2);
    end
  endtask

  task automatic test_edges();
    int lat, bc;
    run_op(16'hFFFF, 16'hFFFF, MODE_ADD, 1'b0, lat, bc);
    checks++;
    if ({ovf, cout, result} !== {2'b01, 16'hFFFE}) begin
      failures++; $display("FAIL add_ffff got=%b%b_%h exp=01_fffe", ovf, cout, result);
    end
    run_op(16'h0000, 16'h0000, MODE_ADD, 1'b1, lat, bc);
    checks++;
    if ({ovf, cout, result} !== {2'b00, 16'h0001}) begin
      failures++; $display("FAIL add_cin got=%b%b_%h exp=00_0001", ovf, cout, result);
    end
    run_op(16'h0FFF, 16'h0001, MODE_ADD, 1'b0, lat, bc);
    checks++;
    if ({ovf, cout, result} !== {2'b00, 16'h1000}) begin
      failures++; $display("FAIL chunk_carry got=%b%b_%h exp=00_1000", ovf, cout, result);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a = 16'h0100; b = 16'h0023; sub = MODE_ADD; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    while (!done && lat < 64) begin
      start = (lat == 1 || lat == 2);
      a = 16'h5555; b = 16'h1111;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat !== NC || result !== 16'h0123) begin
      failures++; $display("FAIL ignore_start got=lat%0d_%h exp=lat%0d_0123", lat, result, NC);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(16'h0010, 16'h0020, MODE_ADD, 1'b0, lat, bc);
    a = 16'h0300; b = 16'h0100; sub = MODE_SUB; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || result !== 16'h0030) begin
      failures++; $display("FAIL b2b_accept got=d%b_b%b_%h exp=d0_b1_0030", done, busy, result);
    end
    lat = 0;
    while (!done && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== NC || {cout, result} !== {1'b1, 16'h0200}) begin
      failures++; $display("FAIL b2b_second got=lat%0d_%b_%h exp=lat%0d_1_0200", lat, cout, result, NC);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, bc;
    logic saw_done;
    run_op(16'h7FFF, 16'h7FFF, MODE_ADD, 1'b1, lat, bc);
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = MODE_ADD; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || {busy, cout, ovf, result} !== {3'b000, 16'h0000}) begin
      failures++;
      $display("FAIL reset_midrun got=done%b_%b%b%b_%h exp=done0_000_0000",
               saw_done, busy, cout, ovf, result);
    end
  endtask

  task automatic test_random();
    int lat, bc, bad;
    logic [W-1:0] ra, rb;
    logic rs, rc;
    logic [W+1:0] exp;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = 16'h8000; rb = 16'h8000; rs = MODE_ADD; rc = 1'b0; end
      exp = model(ra, rb, rs, rc);
      run_op(ra, rb, rs, rc, lat, bc);
      checks++;
      if (lat !== NC || {ovf, cout, result} !== exp) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL random_%0d a=%h b=%h s=%b c=%b got=lat%0d_%b%b_%h exp=%b%b_%h",
                   i, ra, rb, rs, rc, lat, ovf, cout, result, exp[W+1], exp[W], exp[W-1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_edges();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
